// File: rtl/tlc_pkg.sv
// Shared types and default constants for the traffic-light sensor front end.
package tlc_pkg;

    typedef enum logic [1:0] {
        LOW,
        RISE,
        HIGH,
        FALL
    } db_state_t;

    localparam int TLC_DB_CYCLES = 4;
    localparam int TLC_CARS_W    = 8;

endpackage

// File: rtl/tlc_sensor_conditioner_if.sv
// Detector-side bus of tlc_sensor_conditioner: raw detector and ACK in, clean request and count out.
interface tlc_sensor_conditioner_if
    import tlc_pkg::*;
#(
    parameter int CARS_W = TLC_CARS_W
);

    logic              RAW_SENSOR;
    logic              ACK;
    logic              SENSOR;
    logic              DB_LEVEL;
    logic [CARS_W-1:0] CARS;

    modport master (
        output RAW_SENSOR,
        output ACK,
        input  SENSOR,
        input  DB_LEVEL,
        input  CARS
    );

    modport slave (
        input  RAW_SENSOR,
        input  ACK,
        output SENSOR,
        output DB_LEVEL,
        output CARS
    );

endinterface

// File: rtl/tlc_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both stages reset to 0.
module tlc_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make meta and q a true two-stage shift, not one wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tlc_sensor_conditioner.sv
// Synchronizes and debounces the farm-road detector and counts arrivals since last service.
// Define TLC_SENSOR_LATCH_EN to make SENSOR a sticky request that only ACK clears.
module tlc_sensor_conditioner
    import tlc_pkg::*;
#(
    parameter int DB_CYCLES = TLC_DB_CYCLES,
    parameter int CNT_W     = 4,
    parameter int CARS_W    = TLC_CARS_W
) (
    input logic                        CLK,
    input logic                        RST,
    tlc_sensor_conditioner_if.slave    bus
);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES);
    localparam logic [CARS_W-1:0] CARS_MAX = '1;
    localparam bit                SINGLE   = (DB_CYCLES == 1);

    if (DB_CYCLES < 1 || DB_CYCLES > 15 || (DB_CYCLES >> CNT_W) != 0) begin : g_bad_params
        $error("tlc_sensor_conditioner: DB_CYCLES must be 1..15 and below 2**CNT_W");
    end

    logic              s_sync;
    db_state_t         state;
    db_state_t         state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  cnt_inc;
    logic              db_level;
    logic              arrival;
    logic [CARS_W-1:0] cars;

    tlc_sync2 u_sync (
        .clk   (CLK),
        .rst_n (RST),
        .d     (bus.RAW_SENSOR),
        .q     (s_sync)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= LOW;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign cnt_inc = cnt + CNT_W'(1);

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            LOW: begin
                if (s_sync) begin
                    state_next = SINGLE ? HIGH : RISE;
                    cnt_next   = SINGLE ? '0 : CNT_W'(1);
                end
            end
            RISE: begin
                if (!s_sync) begin
                    state_next = LOW;
                    cnt_next   = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            HIGH: begin
                if (!s_sync) begin
                    state_next = SINGLE ? LOW : FALL;
                    cnt_next   = SINGLE ? '0 : CNT_W'(1);
                end
            end
            FALL: begin
                if (s_sync) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    state_next = LOW;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            default: begin
                state_next = LOW;
                cnt_next   = '0;
            end
        endcase
    end

    // The debounced level is high exactly while the FSM sits on the stable-1 side.
    assign db_level = (state == HIGH) || (state == FALL);
    assign arrival  = !db_level && (state_next == HIGH);

    // An arrival coinciding with ACK counts as the first car of the new wait.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cars <= '0;
        end else if (bus.ACK) begin
            cars <= arrival ? CARS_W'(1) : '0;
        end else if (arrival && cars != CARS_MAX) begin
            cars <= cars + CARS_W'(1);
        end
    end

`ifdef TLC_SENSOR_LATCH_EN
    logic sensor_req;

    // Set has priority so a car arriving during green is not lost.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sensor_req <= 1'b0;
        end else if (arrival) begin
            sensor_req <= 1'b1;
        end else if (bus.ACK) begin
            sensor_req <= 1'b0;
        end
    end

    assign bus.SENSOR = sensor_req;
`else
    assign bus.SENSOR = db_level;
`endif

    assign bus.DB_LEVEL = db_level;
    assign bus.CARS     = cars;

endmodule

// File: tb/tb_tlc_sensor_conditioner.sv
// Self-checking bench for tlc_sensor_conditioner: directed scenarios plus random traffic vs. a window model.
module tb_tlc_sensor_conditioner;

    localparam int DB       = 4;
    localparam int CARS_W   = 8;
    localparam int CARS_MAX = 255;
`ifdef TLC_SENSOR_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;

    tlc_sensor_conditioner_if #(.CARS_W(CARS_W)) bus ();

    tlc_sensor_conditioner dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, expected, $time);
        end
    endtask

    // Reference: two-sample synchronizer delay, then the level follows the synchronized input
    // once the last DB samples all agree on the new value.
    typedef struct packed {
        logic          s1;
        logic          s2;
        logic [DB-1:0] hist;
        logic          level;
        int            cars;
        logic          sticky;
    } model_t;

    model_t m;

    function automatic model_t model_step(input model_t cur, input logic raw, input logic ack);
        model_t nxt    = cur;
        logic   arrive = 1'b0;
        nxt.hist = {cur.hist[DB-2:0], cur.s2};
        if (!cur.level && nxt.hist == '1) begin
            nxt.level = 1'b1;
            arrive    = 1'b1;
        end else if (cur.level && nxt.hist == '0) begin
            nxt.level = 1'b0;
        end
        if (ack)
            nxt.cars = arrive ? 1 : 0;
        else if (arrive && cur.cars < CARS_MAX)
            nxt.cars = cur.cars + 1;
        if (arrive)
            nxt.sticky = 1'b1;
        else if (ack)
            nxt.sticky = 1'b0;
        nxt.s2 = cur.s1;
        nxt.s1 = raw;
        return nxt;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST)
            m <= '0;
        else
            m <= model_step(m, bus.RAW_SENSOR, bus.ACK);
    end

    task automatic tick(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check($sformatf("%s.db_level", tag), 32'(bus.DB_LEVEL), 32'(m.level));
            check($sformatf("%s.sensor", tag), 32'(bus.SENSOR), LATCH ? 32'(m.sticky) : 32'(m.level));
            check($sformatf("%s.cars", tag), 32'(bus.CARS), 32'(m.cars));
        end
    endtask

    task automatic ack_pulse(input string tag);
        bus.ACK = 1'b1;
        tick(1, tag);
        bus.ACK = 1'b0;
    endtask

    task automatic check_latency(input string tag);
        for (int e = 1; e <= DB + 2; e++) begin
            tick(1, tag);
            check($sformatf("%s.edge%0d", tag, e), 32'(bus.DB_LEVEL), 32'(e == DB + 2));
        end
    endtask

    initial begin
        int hold;
        RST            = 1'b1;
        bus.RAW_SENSOR = 1'b1;
        bus.ACK        = 1'b0;
        #1 RST = 1'b0;
        #1;
        check("reset.db_level", 32'(bus.DB_LEVEL), 32'd0);
        check("reset.sensor", 32'(bus.SENSOR), 32'd0);
        check("reset.cars", 32'(bus.CARS), 32'd0);
        @(negedge CLK);
        check("reset_hold.db_level", 32'(bus.DB_LEVEL), 32'd0);
        check("reset_hold.cars", 32'(bus.CARS), 32'd0);
        RST = 1'b1;

        // Raw already high at release: level rises on the 6th edge.
        check_latency("rst_release");
        check("rst_release.cars", 32'(bus.CARS), 32'd1);
        check("rst_release.sensor", 32'(bus.SENSOR), 32'd1);

        bus.RAW_SENSOR = 1'b0;
        tick(8, "fall");
        check("fall.db_level", 32'(bus.DB_LEVEL), 32'd0);
        ack_pulse("ack0");
        check("ack0.cars", 32'(bus.CARS), 32'd0);

        // Bounce: 20 ns toggles, then a steady high.
        for (int i = 0; i < 8; i++) begin
            bus.RAW_SENSOR = ((i / 2) % 2) == 0;
            tick(1, "bounce");
            check("bounce.no_change", 32'(bus.DB_LEVEL), 32'd0);
        end
        bus.RAW_SENSOR = 1'b1;
        check_latency("settle");
        tick(6, "settle_hold");
        check("settle.cars_once", 32'(bus.CARS), 32'd1);

        bus.RAW_SENSOR = 1'b0;
        tick(8, "glitch_prep");
        ack_pulse("ack1");

        // 30 ns glitch is one sample short of qualifying.
        bus.RAW_SENSOR = 1'b1;
        tick(3, "glitch");
        bus.RAW_SENSOR = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1, "glitch_after");
            check("glitch.db_level", 32'(bus.DB_LEVEL), 32'd0);
        end
        check("glitch.sensor", 32'(bus.SENSOR), 32'd0);
        check("glitch.cars", 32'(bus.CARS), 32'd0);

        // Three qualified pulses; the sticky request survives the low gaps.
        for (int p = 0; p < 3; p++) begin
            bus.RAW_SENSOR = 1'b1;
            tick(10, "pulse_hi");
            bus.RAW_SENSOR = 1'b0;
            tick(10, "pulse_lo");
            check($sformatf("pulse%0d.sensor_gap", p), 32'(bus.SENSOR), 32'(LATCH));
            check($sformatf("pulse%0d.cars", p), 32'(bus.CARS), 32'(p + 1));
        end
        ack_pulse("ack2");
        check("ack2.cars", 32'(bus.CARS), 32'd0);
        check("ack2.sensor", 32'(bus.SENSOR), 32'd0);

        // Arrival and ACK on the same edge.
        bus.RAW_SENSOR = 1'b1;
        tick(DB + 1, "simul_prep");
        check("simul.pre_db", 32'(bus.DB_LEVEL), 32'd0);
        ack_pulse("simul");
        check("simul.db_level", 32'(bus.DB_LEVEL), 32'd1);
        check("simul.cars", 32'(bus.CARS), 32'd1);
        check("simul.sensor", 32'(bus.SENSOR), 32'd1);
        bus.RAW_SENSOR = 1'b0;
        tick(8, "simul_fall");
        ack_pulse("ack3");

        // Saturation of the vehicle counter.
        for (int p = 1; p <= 257; p++) begin
            bus.RAW_SENSOR = 1'b1;
            tick(6, "sat_hi");
            bus.RAW_SENSOR = 1'b0;
            tick(6, "sat_lo");
            if (p == 254) check("sat.cars254", 32'(bus.CARS), 32'd254);
            if (p == 255) check("sat.cars255", 32'(bus.CARS), 32'd255);
        end
        check("sat.cars_hold", 32'(bus.CARS), 32'd255);

        // Asynchronous reset while the debouncer is counting ones.
        bus.RAW_SENSOR = 1'b1;
        tick(3, "mid_rise");
        #2 RST = 1'b0;
        #1;
        check("async_rst.db_level", 32'(bus.DB_LEVEL), 32'd0);
        check("async_rst.sensor", 32'(bus.SENSOR), 32'd0);
        check("async_rst.cars", 32'(bus.CARS), 32'd0);
        tick(1, "in_reset");
        RST = 1'b1;
        check_latency("requalify");
        check("requalify.cars", 32'(bus.CARS), 32'd1);

        // Random traffic with occasional service.
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                bus.RAW_SENSOR = 1'($urandom_range(0, 1));
                hold           = int'($urandom_range(1, 8));
            end
            hold--;
            bus.ACK = ($urandom_range(0, 15) == 0);
            tick(1, "random");
        end
        bus.ACK = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
